hs_out_serializer: RTL and testbench

- Sits directly downstream of the 16-lane hard-swish stage (hs_block).
- Captures each 16-lane activation vector (OUT_SIZE bits per lane) when that stage's valid pulses, and buffers up to FIFO_DEPTH vectors.
- Emits each vector as BEAT_LANES-lane beats on a ready/valid write bus, with an incrementing feature-map address, per-vector last flag and per-frame done pulse.

---
 rtl/hs_out_serializer.sv | 112 +++++++++++
 tb/tb_hs_out_serializer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_out_serializer.sv
// hs_out_serializer: buffers 16-lane activation vectors from hs_block and replays each as
// BEAT_LANES-wide beats on a ready/valid write bus with a feature-map address.
//
// Ports:
//   clk, rst (async, active-low), en (global enable), clear (sync frame restart)
//   frame_len   vectors per frame (0 = unbounded)
//   in_data / in_valid / in_ready   vector capture side (in_ready is advisory)
//   out_data / out_valid / out_ready / out_addr / out_last   beat write bus
//   frame_done  one-cycle pulse on the final beat of a frame
//   overflow    sticky flag, set when a vector arrives while the buffer is full
module hs_out_serializer #(
  parameter int unsigned OUT_SIZE   = 14,
  parameter int unsigned LANES      = 16,
  parameter int unsigned BEAT_LANES = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             clear,
  input  logic [ADDR_WIDTH-1:0]            frame_len,
  input  logic [OUT_SIZE*LANES-1:0]        in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [OUT_SIZE*BEAT_LANES-1:0]   out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ADDR_WIDTH-1:0]            out_addr,
  output logic                             out_last,
  output logic                             frame_done,
  output logic                             overflow
);

  localparam int unsigned VecW  = OUT_SIZE * LANES;
  localparam int unsigned BeatW = OUT_SIZE * BEAT_LANES;
  localparam int unsigned BEATS = LANES / BEAT_LANES;
  localparam int unsigned BcW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  logic [VecW-1:0]       mem [FIFO_DEPTH];
  logic [CntW-1:0]       count_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [BcW-1:0]        beat_q;
  logic [ADDR_WIDTH-1:0] vec_cnt_q, addr_q;
  logic                  overflow_q;

  logic            full, last_beat, xfer, retire, push, drop, frame_end;
  logic [VecW-1:0] head;

  always_comb begin
    full      = (count_q == CntW'(FIFO_DEPTH));
    in_ready  = en & ~full;
    out_valid = (count_q != '0);
    last_beat = (beat_q == BcW'(BEATS - 1));
    out_last  = out_valid & last_beat;
    xfer      = en & out_valid & out_ready;
    retire    = xfer & last_beat;
    // Full is judged on the registered count only, so a same-cycle retire never rescues a push.
    push      = en & in_valid & ~full;
    drop      = en & in_valid & full;
    frame_end = (frame_len != '0) & (vec_cnt_q == frame_len - ADDR_WIDTH'(1));
    frame_done = retire & frame_end;
    head      = mem[rd_ptr_q];
    out_data  = out_valid ? head[int'(beat_q) * BeatW +: BeatW] : '0;
    out_addr  = addr_q;
    overflow  = overflow_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      vec_cnt_q  <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      vec_cnt_q  <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (retire) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !retire)      count_q <= count_q + CntW'(1);
      else if (retire && !push) count_q <= count_q - CntW'(1);
      if (drop) overflow_q <= 1'b1;
      if (xfer) begin
        beat_q <= last_beat ? '0 : beat_q + BcW'(1);
        if (frame_done) begin
          addr_q    <= '0;
          vec_cnt_q <= '0;
        end else begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          if (retire) vec_cnt_q <= vec_cnt_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_hs_out_serializer.sv
module tb_hs_out_serializer;

  localparam int OS = 14;
  localparam int L  = 16;
  localparam int BL = 4;
  localparam int D  = 4;
  localparam int AW = 12;
  localparam int VW = OS * L;
  localparam int BW = OS * BL;

  typedef logic [VW-1:0] vec_t;
  typedef logic [BW-1:0] beat_t;

  logic          clk, rst, en, clear, in_valid, in_ready, out_valid, out_ready;
  logic          out_last, frame_done, overflow;
  logic [AW-1:0] frame_len, out_addr;
  vec_t          in_data;
  beat_t         out_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a queue of whole vectors plus beat/vector/address bookkeeping.
  vec_t          mq[$];
  int            m_beat;
  logic [AW-1:0] m_vcnt, m_addr;
  bit            m_ovf;

  logic          e_valid, e_last, e_done, e_ready, e_ovf;
  beat_t         e_data;
  logic [AW-1:0] e_addr;

  hs_out_serializer #(
    .OUT_SIZE(OS), .LANES(L), .BEAT_LANES(BL), .FIFO_DEPTH(D), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .frame_len(frame_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_last(out_last), .frame_done(frame_done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_beat = 0;
    m_vcnt = '0;
    m_addr = '0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_update();
    int cnt;
    bit fin;
    if (clear) begin
      model_reset();
    end else if (en) begin
      cnt = mq.size();
      if (cnt != 0 && out_ready) begin
        fin = (m_beat == BL - 1) && frame_len != 0 && m_vcnt == frame_len - 12'd1;
        if (fin) begin
          m_addr = '0;
          m_vcnt = '0;
        end else begin
          m_addr = m_addr + 12'd1;
          if (m_beat == L / BL - 1) m_vcnt = m_vcnt + 12'd1;
        end
        if (m_beat == L / BL - 1) begin
          void'(mq.pop_front());
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (in_valid) begin
        if (cnt < D) mq.push_back(in_data);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compute_exp();
    vec_t h;
    e_valid = (mq.size() != 0);
    h       = e_valid ? mq[0] : '0;
    e_data  = e_valid ? h[m_beat*BW +: BW] : '0;
    e_last  = e_valid && (m_beat == L / BL - 1);
    e_done  = e_last && out_ready && en && frame_len != 0 && m_vcnt == frame_len - 12'd1;
    e_ready = en && (mq.size() < D);
    e_addr  = m_addr;
    e_ovf   = m_ovf;
  endtask

  // Advance one clock edge and keep the model in step.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_update();
    #1;
  endtask

  function automatic vec_t ramp_vec();
    vec_t v;
    for (int i = 0; i < L; i++) v[i*OS +: OS] = OS'(i);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int w = 0; w < VW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    #2;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++;
    if (out_data !== '0) begin n_errors++; $display("FAIL reset_data got %h want 0", out_data); end
    n_checks++;
    if (out_addr !== '0) begin n_errors++; $display("FAIL reset_addr got %0d want 0", out_addr); end
    n_checks++;
    if ({out_last, frame_done, overflow} !== 3'b000) begin
      n_errors++; $display("FAIL reset_flags got %b want 000", {out_last, frame_done, overflow});
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single();
    vec_t  v;
    beat_t w;
    v = ramp_vec();
    in_data = v; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int b = 0; b < L / BL; b++) begin
      for (int j = 0; j < BL; j++) w[j*OS +: OS] = OS'(b * BL + j);
      #2;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== w) begin
        n_errors++; $display("FAIL single_data b%0d got v=%b %h want v=1 %h", b, out_valid, out_data, w);
      end
      n_checks++;
      if (out_addr !== AW'(b) || out_last !== (b == L / BL - 1)) begin
        n_errors++; $display("FAIL single_addr_last b%0d got %0d/%b want %0d/%b", b, out_addr,
                             out_last, b, (b == L / BL - 1));
      end
      tick();
    end
    #2;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_drop got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    vec_t          v;
    logic [AW-1:0] base;
    v = rand_vec();
    base = m_addr;
    in_data = v; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    repeat (3) begin
      #2;
      n_checks++;
      if (out_data !== v[1*BW +: BW] || out_addr !== base + 12'd1 || out_last !== 1'b0) begin
        n_errors++; $display("FAIL bp_hold got %h/%0d/%b want %h/%0d/0", out_data, out_addr,
                             out_last, v[1*BW +: BW], base + 12'd1);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int b = 1; b < L / BL; b++) begin
      #2;
      n_checks++;
      if (out_data !== v[b*BW +: BW] || out_addr !== base + AW'(b)) begin
        n_errors++; $display("FAIL bp_resume b%0d got %h/%0d want %h/%0d", b, out_data, out_addr,
                             v[b*BW +: BW], base + AW'(b));
      end
      tick();
    end
    #2;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    vec_t vs[5];
    clear = 1'b1; tick(); clear = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vs[k] = rand_vec();
      in_data = vs[k]; in_valid = 1'b1;
      #2;
      n_checks++;
      if (in_ready !== (k < D)) begin
        n_errors++; $display("FAIL ovf_in_ready k%0d got %b want %b", k, in_ready, (k < D));
      end
      tick();
    end
    in_valid = 1'b0;
    #2;
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    out_ready = 1'b1;
    for (int k = 0; k < D; k++) begin
      for (int b = 0; b < L / BL; b++) begin
        #2;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== vs[k][b*BW +: BW]) begin
          n_errors++; $display("FAIL ovf_drain v%0d b%0d got %b %h want 1 %h", k, b, out_valid,
                               out_data, vs[k][b*BW +: BW]);
        end
        tick();
      end
    end
    #2;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_fifth got %b want 0", out_valid); end
    clear = 1'b1; tick(); clear = 1'b0;
    #2;
    n_checks++;
    if (overflow !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL ovf_clear got ovf=%b v=%b rdy=%b want 0 0 1", overflow, out_valid,
                           in_ready);
    end
  endtask

  task automatic test_frame();
    vec_t vs[3];
    int   dones;
    clear = 1'b1; tick(); clear = 1'b0;
    frame_len = 12'd2;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vs[k] = rand_vec();
      in_data = vs[k]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      #2;
      if (frame_done === 1'b1) dones++;
      n_checks++;
      if (out_addr !== AW'(k < 8 ? k : k - 8) || frame_done !== (k == 7)) begin
        n_errors++; $display("FAIL frame_beat k%0d got addr=%0d done=%b want %0d/%b", k, out_addr,
                             frame_done, (k < 8 ? k : k - 8), (k == 7));
      end
      n_checks++;
      if (out_data !== vs[k/4][(k%4)*BW +: BW] || out_last !== (k % 4 == 3)) begin
        n_errors++; $display("FAIL frame_data k%0d got %h/%b want %h/%b", k, out_data, out_last,
                             vs[k/4][(k%4)*BW +: BW], (k % 4 == 3));
      end
      tick();
    end
    n_checks++;
    if (dones != 1) begin n_errors++; $display("FAIL frame_done_count got %0d want 1", dones); end
    frame_len = '0;
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_simul();
    vec_t vs[5];
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vs[k] = rand_vec();
      in_data = vs[k]; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    vs[3] = rand_vec();
    in_data = vs[3]; in_valid = 1'b1;
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || out_last !== 1'b1) begin
      n_errors++; $display("FAIL simul_pre got rdy=%b last=%b want 1 1", in_ready, out_last);
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL simul_count3 got %b want 1", in_ready); end
    vs[4] = rand_vec();
    in_data = vs[4]; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL simul_count4 got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      for (int b = 0; b < L / BL; b++) begin
        #2;
        n_checks++;
        if (out_data !== vs[k][b*BW +: BW]) begin
          n_errors++; $display("FAIL simul_order v%0d b%0d got %h want %h", k, b, out_data,
                               vs[k][b*BW +: BW]);
        end
        tick();
      end
    end
  endtask

  task automatic test_en_reset();
    vec_t  v;
    vec_t  r;
    beat_t w;
    clear = 1'b1; tick(); clear = 1'b0;
    v = rand_vec();
    in_data = v; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    en = 1'b0;
    repeat (2) begin
      #2;
      n_checks++;
      if (out_data !== v[BW +: BW] || out_addr !== 12'd1 || in_ready !== 1'b0 || out_valid !== 1'b1)
      begin
        n_errors++; $display("FAIL en_freeze got %h/%0d/rdy=%b want %h/1/rdy=0", out_data, out_addr,
                             in_ready, v[BW +: BW]);
      end
      tick();
    end
    en = 1'b1;
    tick();
    #2;
    n_checks++;
    if (out_addr !== 12'd2 || out_data !== v[2*BW +: BW]) begin
      n_errors++; $display("FAIL en_resume got %0d/%h want 2/%h", out_addr, out_data, v[2*BW +: BW]);
    end
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_addr !== '0 || out_data !== '0) begin
      n_errors++; $display("FAIL rst_mid got v=%b addr=%0d data=%h want 0 0 0", out_valid, out_addr,
                           out_data);
    end
    tick();
    rst = 1'b1;
    r = ramp_vec();
    in_data = r; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < BL; j++) w[j*OS +: OS] = OS'(j);
    #2;
    n_checks++;
    if (out_valid !== 1'b1 || out_addr !== '0 || out_data !== w) begin
      n_errors++; $display("FAIL rst_restart got v=%b addr=%0d %h want 1 0 %h", out_valid, out_addr,
                           out_data, w);
    end
    repeat (4) tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] lens[4];
    lens[0] = 12'd0; lens[1] = 12'd1; lens[2] = 12'd2; lens[3] = 12'd3;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // frame_len only changes together with a clear.
      if (cyc % 100 == 0) begin
        clear = 1'b1;
        frame_len = lens[$urandom_range(3)];
      end else begin
        clear = ($urandom_range(49) == 0);
      end
      en        = ($urandom_range(9) != 0);
      in_valid  = $urandom_range(1);
      in_data   = rand_vec();
      out_ready = ($urandom_range(2) != 0);
      #2;
      compute_exp();
      n_checks++;
      if (out_valid !== e_valid || out_data !== e_data) begin
        n_errors++; $display("FAIL rnd_data c%0d got %b %h want %b %h", cyc, out_valid, out_data,
                             e_valid, e_data);
      end
      n_checks++;
      if (out_addr !== e_addr || out_last !== e_last) begin
        n_errors++; $display("FAIL rnd_addr c%0d got %0d/%b want %0d/%b", cyc, out_addr, out_last,
                             e_addr, e_last);
      end
      n_checks++;
      if (frame_done !== e_done || in_ready !== e_ready || overflow !== e_ovf) begin
        n_errors++; $display("FAIL rnd_flags c%0d got d=%b r=%b o=%b want d=%b r=%b o=%b", cyc,
                             frame_done, in_ready, overflow, e_done, e_ready, e_ovf);
      end
      tick();
    end
    clear = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    frame_len = '0; in_data = '0;
    model_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_frame();
    test_simul();
    test_en_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
